// File: rtl/btn_conditioner.sv
// Push-button front-end: per-channel synchroniser, debounce filter, edge pulses
// and hold-to-repeat, so the game core only sees clean levels and 1-cycle events.
module btn_conditioner #(
  parameter int                 NUM_BTN         = 3,
  parameter logic [NUM_BTN-1:0] INVERT_MASK     = '0,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 125000,
  parameter int                 REPEAT_EN       = 1,
  parameter int                 REPEAT_DELAY    = 6250000,
  parameter int                 REPEAT_RATE     = 2500000
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  // state    | meaning
  // ST_IDLE  | button released (or block disabled), no repeat pending
  // ST_DELAY | held since press, waiting REPEAT_DELAY for the first repeat
  // ST_RPT   | auto-repeating, one pulse every REPEAT_RATE cycles
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_TC   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LD  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RATE_LD = TMR_W'(REPEAT_RATE - 1);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   stable_q, stable_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [1:0]             state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;

    // Synchroniser keeps running while disabled so re-enable only costs the debounce time.
    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[g] ^ INVERT_MASK[g]};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
      stable_d  = stable_q;
      db_cnt_d  = db_cnt_q;
      state_d   = state_q;
      tmr_d     = tmr_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      if (!en) begin
        stable_d = 1'b0;
        db_cnt_d = '0;
        state_d  = ST_IDLE;
        tmr_d    = '0;
      end else begin
        if (synced == stable_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_TC) begin
          stable_d  = synced;
          db_cnt_d  = '0;
          press_d   = synced;
          release_d = ~synced;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end

        if (REPEAT_EN != 0) begin
          case (state_q)
            ST_IDLE: begin
              if (press_d) begin
                state_d = ST_DELAY;
                tmr_d   = DLY_LD;
              end
            end
            ST_DELAY, ST_RPT: begin
              // Release takes priority over a timer expiring in the same cycle.
              if (release_d) begin
                state_d = ST_IDLE;
                tmr_d   = '0;
              end else if (tmr_q == '0) begin
                state_d  = ST_RPT;
                tmr_d    = RATE_LD;
                repeat_d = 1'b1;
              end else begin
                tmr_d = tmr_q - 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
              tmr_d   = '0;
            end
          endcase
        end
        repeat_d = repeat_d | press_d;
      end
    end

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        stable_q  <= 1'b0;
        db_cnt_q  <= '0;
        state_q   <= ST_IDLE;
        tmr_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        stable_q  <= stable_d;
        db_cnt_q  <= db_cnt_d;
        state_q   <= state_d;
        tmr_q     <= tmr_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
      end
    end

    assign btn_level[g]   = stable_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_repeat[g]  = repeat_q;
  end

endmodule
